// File: rtl/sysclk_tick_gen.sv
// Timebase for the PLL clock domain: post-reset holdoff, programmable ADC sample strobe,
// 1 ms tick and, when SEC_TICK_EN is defined, a 1 s tick, all phase-aligned.
module sysclk_tick_gen #(
  parameter int unsigned CLK_HZ      = 64800000,
  parameter int unsigned HOLDOFF_CYC = 4096,
  parameter int unsigned DIV_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             sync_clr,
  output logic             ready,
  output logic             sample_stb,
  output logic             ms_stb,
  output logic             sec_stb
);

  localparam int unsigned MS_CYC = CLK_HZ / 1000;
  localparam int unsigned MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int unsigned HO_W   = $clog2(HOLDOFF_CYC);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_CYC - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYC - 1);

  if (CLK_HZ % 1000 != 0) begin : g_bad_clk_hz
    $error("sysclk_tick_gen: CLK_HZ must be a multiple of 1000");
  end
  if (HOLDOFF_CYC < 2) begin : g_bad_holdoff
    $error("sysclk_tick_gen: HOLDOFF_CYC must be at least 2");
  end

  logic [HO_W-1:0]  hold_cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_next;
  logic [DIV_W-1:0] samp_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             samp_wrap;
  logic             ms_wrap;

  always_comb begin
    div_next  = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
    samp_wrap = (samp_cnt == div_eff - DIV_W'(1));
    ms_wrap   = (ms_cnt == MS_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      ready    <= 1'b0;
    end else if (!ready) begin
      if (hold_cnt == HO_LAST) ready <= 1'b1;
      else                     hold_cnt <= hold_cnt + HO_W'(1);
    end
  end

  // div_eff tracks div_ratio during holdoff so the first period after ready uses the programmed ratio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_eff    <= DIV_W'(1);
      samp_cnt   <= '0;
      ms_cnt     <= '0;
      sample_stb <= 1'b0;
      ms_stb     <= 1'b0;
    end else if (!ready) begin
      div_eff <= div_next;
    end else if (sync_clr) begin
      div_eff    <= div_next;
      samp_cnt   <= '0;
      ms_cnt     <= '0;
      sample_stb <= 1'b0;
      ms_stb     <= 1'b0;
    end else begin
      sample_stb <= samp_wrap;
      ms_stb     <= ms_wrap;
      if (samp_wrap) begin
        samp_cnt <= '0;
        div_eff  <= div_next;
      end else begin
        samp_cnt <= samp_cnt + DIV_W'(1);
      end
      if (ms_wrap) ms_cnt <= '0;
      else         ms_cnt <= ms_cnt + MS_W'(1);
    end
  end

`ifdef SEC_TICK_EN
  logic [9:0] sec_cnt;
  logic       sec_last;

  always_comb sec_last = (sec_cnt == 10'd999);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
      sec_stb <= 1'b0;
    end else if (!ready) begin
      sec_stb <= 1'b0;
    end else if (sync_clr) begin
      sec_cnt <= '0;
      sec_stb <= 1'b0;
    end else begin
      sec_stb <= ms_wrap && sec_last;
      if (ms_wrap) sec_cnt <= sec_last ? '0 : sec_cnt + 10'd1;
    end
  end
`else
  assign sec_stb = 1'b0;
`endif

endmodule

// File: tb/tb_sysclk_tick_gen.sv
// Self-checking bench for sysclk_tick_gen: directed phases plus randomized ratio/clear
// traffic, checked against an edge-timestamp model of when each strobe is due.
module tb_sysclk_tick_gen;

  localparam int unsigned CLK_HZ = 10000;
  localparam int unsigned HOLD   = 16;
  localparam int unsigned DIV_W  = 8;
  localparam int          MS     = CLK_HZ / 1000;
`ifdef SEC_TICK_EN
  localparam bit SEC_ON = 1'b1;
`else
  localparam bit SEC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sync_clr = 1'b0;
  logic [DIV_W-1:0] div_ratio = DIV_W'(4);
  logic             ready, sample_stb, ms_stb, sec_stb;

  int n_pass = 0;
  int n_total = 0;

  // Model: edge index since reset release and absolute edges at which strobes are due
  int e;
  bit m_ready;
  int next_samp, next_ms, ms_n;

  sysclk_tick_gen #(
    .CLK_HZ(CLK_HZ),
    .HOLDOFF_CYC(HOLD),
    .DIV_W(DIV_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .div_ratio(div_ratio),
    .sync_clr(sync_clr),
    .ready(ready),
    .sample_stb(sample_stb),
    .ms_stb(ms_stb),
    .sec_stb(sec_stb)
  );

  always #5 clk = ~clk;

  function automatic int eff(logic [DIV_W-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  task automatic chk_bit(string tag, logic obs, logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
  endtask

  task automatic model_reset();
    e = 0;
    m_ready = 1'b0;
    next_samp = 0;
    next_ms = 0;
    ms_n = 0;
  endtask

  task automatic step();
    int r;
    bit es, em, esec;
    @(posedge clk);
    e++;
    r = eff(div_ratio);
    es = 1'b0; em = 1'b0; esec = 1'b0;
    if (!m_ready) begin
      if (e == HOLD) begin
        m_ready = 1'b1;
        next_samp = e + r;
        next_ms = e + MS;
        ms_n = 0;
      end
    end else if (sync_clr) begin
      next_samp = e + r;
      next_ms = e + MS;
      ms_n = 0;
    end else begin
      if (e == next_samp) begin
        es = 1'b1;
        next_samp = e + r;
      end
      if (e == next_ms) begin
        em = 1'b1;
        next_ms = e + MS;
        ms_n++;
        if (ms_n == 1000) begin
          esec = SEC_ON;
          ms_n = 0;
        end
      end
    end
    #1;
    chk_bit("ready", ready, m_ready);
    chk_bit("sample_stb", sample_stb, es);
    chk_bit("ms_stb", ms_stb, em);
    chk_bit("sec_stb", sec_stb, esec);
  endtask

  initial begin
    int q[$];
    int j, t_s, t_m, ready_edge, sec_seen, ms_seen, ms_at_sec;
    bit found;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_ready", ready, 1'b0);
    chk_bit("rst_sample", sample_stb, 1'b0);
    chk_bit("rst_ms", ms_stb, 1'b0);
    chk_bit("rst_sec", sec_stb, 1'b0);
    rst_n = 1'b1;

    // Ratio 4: ready at 16, samples 20,24,..., ms at 26,36
    repeat (42) step();
    div_ratio = DIV_W'(7);
    q.delete();
    repeat (20) begin
      step();
      if (sample_stb) q.push_back(e);
    end
    chk_int("chg_first", (q.size() > 0) ? q[0] : -1, 44);
    chk_int("chg_second", (q.size() > 1) ? q[1] : -1, 51);

    // Clear in the cycle where the ratio-4 counter sits at its last value
    div_ratio = DIV_W'(4);
    repeat (16) step();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (next_samp == e + 1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk_bit("clr_align_found", found, 1'b1);
    sync_clr = 1'b1;
    step();
    j = e;
    sync_clr = 1'b0;
    chk_bit("clr_suppress", sample_stb, 1'b0);
    t_s = -1;
    t_m = -1;
    repeat (12) begin
      step();
      if (sample_stb && t_s < 0) t_s = e;
      if (ms_stb && t_m < 0) t_m = e;
    end
    chk_int("clr_next_samp", t_s, j + 4);
    chk_int("clr_next_ms", t_m, j + MS);

    div_ratio = '0;
    repeat (8) step();
    repeat (10) begin
      step();
      chk_bit("div0_every", sample_stb, 1'b1);
    end
    div_ratio = DIV_W'(1);
    repeat (10) begin
      step();
      chk_bit("div1_every", sample_stb, 1'b1);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) div_ratio = DIV_W'($urandom_range(0, 9));
      sync_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    sync_clr = 1'b0;

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk_bit("arst_ready", ready, 1'b0);
    chk_bit("arst_sample", sample_stb, 1'b0);
    chk_bit("arst_ms", ms_stb, 1'b0);
    chk_bit("arst_sec", sec_stb, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    div_ratio = DIV_W'(5);
    ready_edge = -1;
    sec_seen = 0;
    ms_seen = 0;
    ms_at_sec = -1;
    for (int i = 0; i < int'(HOLD) + 1000 * MS + 20; i++) begin
      step();
      if (ready && ready_edge < 0) ready_edge = e;
      if (ms_stb) ms_seen++;
      if (sec_stb) begin
        sec_seen++;
        ms_at_sec = ms_seen;
      end
    end
    chk_int("ready_edge", ready_edge, HOLD);
    chk_int("sec_count", sec_seen, SEC_ON ? 1 : 0);
    chk_int("sec_at_ms", ms_at_sec, SEC_ON ? 1000 : -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sysclk_tick_gen.md
# sysclk_tick_gen

Timebase generator for the 64.8 MHz PLL output domain. It sits directly downstream of the system PLL and consumes its output clock. The PLL lock signal is not exported, so the block holds off for a fixed cycle count after reset before declaring the domain usable. It then produces a single-cycle ADC sample strobe with a programmable integer ratio, a 1 ms housekeeping tick and an optional 1 s tick, all phase-aligned to one another.

## Interface

Parameters:
- CLK_HZ, 64800000, frequency of `clk` in Hz. Must be a multiple of 1000; elaboration fails otherwise.
- HOLDOFF_CYC, 4096, cycles after reset release before `ready` rises. Must be ≥ 2.
- DIV_W, 8, width of `div_ratio`.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  PLL output clock.
- rst_n  input  1  async active-low reset. Assertion is asynchronous; release is assumed to be synchronous to `clk` (provided by an external synchronizer).
- div_ratio  input  DIV_W  sample strobe period in cycles. Values 0 and 1 are treated as 1.
- sync_clr  input  1  realign request: restarts all divider phases.
- ready  output  1  timebase valid (holdoff expired).
- sample_stb  output  1  one-cycle ADC sample strobe.
- ms_stb  output  1  one-cycle pulse every CLK_HZ/1000 cycles.
- sec_stb  output  1  one-cycle pulse every 1000 ms ticks (only with SEC_TICK_EN).

## Operation

- Reset: all outputs are 0; all counters are 0; the latched divide ratio `div_eff` is 1.
- Holdoff counter:
  - Counts from reset release.
  - `ready` is registered and goes high on the edge after the counter reaches HOLDOFF_CYC-1.
  - `ready` then stays high until the next reset.
- Strobe gating: all strobes are held at 0 while `ready` = 0. Divider counters stay at 0 until `ready` = 1.
- Sample divider:
  - Counter runs 0..div_eff-1.
  - `sample_stb` is high for the cycle following the one in which the counter equals div_eff-1.
  - `div_eff` is reloaded from `div_ratio` (0 maps to 1) only at wrap, or when `sync_clr` is active. A change mid-period never shortens or lengthens the current period.
- ms divider: counter runs 0..CLK_HZ/1000-1 and produces `ms_stb` with the same output structure as the sample divider.
- sec divider: counts `ms_stb` pulses 0..999. `sec_stb` is asserted in the same cycle as the 1000th `ms_stb`.
- sync_clr (1 cycle):
  - Zeroes the sample, ms and sec counters and reloads `div_eff`.
  - Any strobe that would assert on the following edge is suppressed; clear wins over terminal count.
  - While `ready` = 0, `sync_clr` is ignored.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronous) and the holdoff restarts from 0.

## Timing

- `ready` rises at edge number HOLDOFF_CYC after reset release.
- `ready` rises at edge k:
  - The first `sample_stb` is at edge k+div_eff. Its period is exactly div_eff cycles.
  - The first `ms_stb` is at edge k+CLK_HZ/1000.
- `sync_clr` sampled at edge j: the next `sample_stb` is at edge j+div_eff (new ratio), and the next `ms_stb` is at edge j+CLK_HZ/1000.
- Phase relationship: if CLK_HZ/1000 is a multiple of div_eff, `sample_stb` and `ms_stb` coincide on every ms tick.
- Counter widths are sized as clog2 of the terminal count. There is no overflow wrap other than the defined terminal count.

## Configuration

- SEC_TICK_EN defined: the 10-bit sec counter is built and `sec_stb` operates as described.
- SEC_TICK_EN not defined: the sec counter is omitted and `sec_stb` is tied to 0. All other behaviour is unchanged.

## Test plan

Bench parameters: CLK_HZ=10000, HOLDOFF_CYC=16, SEC_TICK_EN defined.

- Reset release, `div_ratio`=4 -> `ready` rises at edge 16; `sample_stb` at edges 20, 24, 28…; `ms_stb` at edges 26, 36…; no strobes before edge 16.
- `div_ratio` 0 and 1 -> `sample_stb` is high on every cycle after `ready`.
- `div_ratio` changed from 4 to 7 two cycles after a strobe -> the next strobe is still 4 cycles after the previous one; subsequent strobes are spaced 7 cycles apart.
- `sync_clr` pulsed in the cycle the sample counter is at 3 of 0..3 -> no strobe at the next edge; the next strobe follows div_eff cycles after the clear; the ms phase restarts.
- Run 10000 cycles past `ready` -> exactly 1 `sec_stb`, coincident with the 1000th `ms_stb`. Rebuild without SEC_TICK_EN -> `sec_stb` is always 0.
- Assert `rst_n` mid-run -> all outputs are 0 within the same cycle; after release, `ready` rises again 16 cycles later.
